fifo_burst_reader: RTL

//  Read-side drain controller for the synchronous FIFO. It reads words out of the FIFO and

---
 rtl/fifo_burst_reader.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - drains the synchronous FIFO into valid/ready bursts of BURST_LEN beats
//
// Reads words from the FIFO read port and presents them downstream as bursts.
// A full burst starts as soon as BURST_LEN words are available.
// A partial burst starts on flush, or after TIMEOUT idle cycles with a non-empty FIFO.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   flush           in IDLE, start a partial burst now if the FIFO holds data
//   fifo_rd_en      FIFO read strobe (combinational)
//   fifo_rd_data    FIFO registered read data, valid one cycle after fifo_rd_en
//   fifo_empty      FIFO empty flag
//   fifo_data_cnt   FIFO occupancy
//   m_valid/m_ready output beat handshake
//   m_data/m_last   output beat data and end-of-burst marker (registered)
//   busy            high while a burst is in progress
`timescale 1ns/1ps
module fifo_burst_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3,
   parameter int BURST_LEN  = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   input  logic                  fifo_empty,
   input  logic [ADDR_WIDTH:0]   fifo_data_cnt,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic                  busy
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] BURST_LEN_C = CW'(BURST_LEN);
   localparam logic [TW-1:0] TMR_LAST    = TW'(TIMEOUT - 1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         blen_q, blen_d;
   logic [CW-1:0]         rd_cnt_q, rd_cnt_d;
   logic [CW-1:0]         tx_cnt_q, tx_cnt_d;
   logic [TW-1:0]         idle_tmr_q, idle_tmr_d;
   logic                  inflight_q, inflight_d;
   logic                  infl_last_q, infl_last_d;
   logic [1:0]            occ_q, occ_d;
   logic [DATA_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
   logic                  last0_q, last0_d, last1_q, last1_d;

   logic       pop;
   logic [2:0] room;
   logic [1:0] occ_kept;

   // buf0 is the head of the skid buffer and drives the output directly.
   assign m_valid = (occ_q != 2'd0);
   assign m_data  = buf0_q;
   assign m_last  = m_valid & last0_q;
   assign busy    = (state_q == BURST);

   always_comb begin
      state_d     = state_q;
      blen_d      = blen_q;
      rd_cnt_d    = rd_cnt_q;
      tx_cnt_d    = tx_cnt_q;
      idle_tmr_d  = idle_tmr_q;
      buf0_d      = buf0_q;
      buf1_d      = buf1_q;
      last0_d     = last0_q;
      last1_d     = last1_q;

      pop = m_valid & m_ready;
      // Occupancy the buffer will have once every read already issued has landed.
      // Issuing another read is only safe while that stays below the buffer depth.
      room = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
      fifo_rd_en = (state_q == BURST) && (rd_cnt_q < blen_q) && !fifo_empty && (room < 3'd2);

      inflight_d  = fifo_rd_en;
      // The end-of-burst marker travels with the data word it belongs to.
      infl_last_d = fifo_rd_en && (rd_cnt_q == blen_q - CW'(1));

      occ_kept = occ_q - {1'b0, pop};
      if (pop) begin
         buf0_d  = buf1_q;
         last0_d = last1_q;
      end
      if (inflight_q) begin
         if (occ_kept == 2'd0) begin
            buf0_d  = fifo_rd_data;
            last0_d = infl_last_q;
         end else begin
            buf1_d  = fifo_rd_data;
            last1_d = infl_last_q;
         end
      end
      occ_d = occ_kept + {1'b0, inflight_q};

      case (state_q)
         IDLE: begin
            if (fifo_data_cnt >= BURST_LEN_C) begin
               state_d    = BURST;
               blen_d     = BURST_LEN_C;
               idle_tmr_d = '0;
               rd_cnt_d   = '0;
               tx_cnt_d   = '0;
            end else if ((fifo_data_cnt != '0) && (flush || (idle_tmr_q == TMR_LAST))) begin
               state_d    = BURST;
               blen_d     = fifo_data_cnt;
               idle_tmr_d = '0;
               rd_cnt_d   = '0;
               tx_cnt_d   = '0;
            end else if (fifo_data_cnt != '0) begin
               idle_tmr_d = idle_tmr_q + TW'(1);
            end else begin
               idle_tmr_d = '0;
            end
         end
         BURST: begin
            rd_cnt_d = rd_cnt_q + CW'(fifo_rd_en);
            tx_cnt_d = tx_cnt_q + CW'(pop);
            if (pop && (tx_cnt_q == blen_q - CW'(1))) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         blen_q      <= '0;
         rd_cnt_q    <= '0;
         tx_cnt_q    <= '0;
         idle_tmr_q  <= '0;
         inflight_q  <= 1'b0;
         infl_last_q <= 1'b0;
         occ_q       <= '0;
         buf0_q      <= '0;
         buf1_q      <= '0;
         last0_q     <= 1'b0;
         last1_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         blen_q      <= blen_d;
         rd_cnt_q    <= rd_cnt_d;
         tx_cnt_q    <= tx_cnt_d;
         idle_tmr_q  <= idle_tmr_d;
         inflight_q  <= inflight_d;
         infl_last_q <= infl_last_d;
         occ_q       <= occ_d;
         buf0_q      <= buf0_d;
         buf1_q      <= buf1_d;
         last0_q     <= last0_d;
         last1_q     <= last1_d;
      end
   end

endmodule
